// File: rtl/jpeg_huffman_block_scheduler.sv
// Block scheduler for the JPEG Huffman encoder: walks every 8x8 block of a frame in buffer order.
// Optional WAIT_BUF stall counter is enabled with `define JPEG_HUFF_SCHED_STALL_COUNT_EN.
module jpeg_huffman_block_scheduler #(
   parameter int NUM_BUFFERS   = 2,
   parameter int LUMA_BLOCKS   = 4,
   parameter int CHROMA_BLOCKS = 2,
   parameter int MCU_WIDTH     = 16,
   localparam int SEL_W        = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
   input  logic                   clock,
   input  logic                   nreset,
   input  logic                   frame_start,
   input  logic [MCU_WIDTH-1:0]   frame_mcus,
   input  logic [NUM_BUFFERS-1:0] buf_full,
   output logic [NUM_BUFFERS-1:0] buf_release,
   output logic [SEL_W-1:0]       buf_sel,
   output logic                   huff_start,
   input  logic                   huff_finished,
   output logic [1:0]             component,
   output logic                   dc_reset,
   output logic                   mcu_done,
   output logic                   frame_done,
   output logic                   busy
`ifdef JPEG_HUFF_SCHED_STALL_COUNT_EN
   ,
   output logic [31:0]            stall_cycles
`endif
);

   localparam int BLOCKS_PER_MCU = LUMA_BLOCKS + CHROMA_BLOCKS;
   localparam int BLK_W          = 3;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BUF,
      START,
      RUN,
      RELEASE
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [BLK_W-1:0]     block_idx_q;
   logic [MCU_WIDTH-1:0] mcu_count_q;
   logic [MCU_WIDTH-1:0] frame_mcus_q;
   logic                 armed_q;

   logic                 last_block;
   logic                 last_mcu;
   logic [BLK_W-1:0]     next_block;
   logic [SEL_W-1:0]     next_sel;

   function automatic logic [1:0] component_of(input logic [BLK_W-1:0] idx);
      if (idx < BLK_W'(LUMA_BLOCKS)) begin
         return 2'd0;
      end else if (idx == BLK_W'(LUMA_BLOCKS)) begin
         return 2'd1;
      end else begin
         return 2'd2;
      end
   endfunction

   assign last_block = (block_idx_q == BLK_W'(BLOCKS_PER_MCU - 1));
   assign last_mcu   = ((mcu_count_q + MCU_WIDTH'(1)) == frame_mcus_q);
   assign next_block = last_block ? '0 : block_idx_q + BLK_W'(1);
   assign next_sel   = (buf_sel == SEL_W'(NUM_BUFFERS - 1)) ? '0 : buf_sel + SEL_W'(1);
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      huff_start  = 1'b0;
      buf_release = '0;
      mcu_done    = 1'b0;
      frame_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) state_d = WAIT_BUF;
         end
         WAIT_BUF: begin
            if (buf_full[buf_sel]) state_d = START;
         end
         START: begin
            huff_start = 1'b1;
            state_d    = RUN;
         end
         RUN: begin
            // A finished level still high from the previous block is ignored until it has been seen low.
            if (armed_q && huff_finished) state_d = RELEASE;
         end
         RELEASE: begin
            buf_release[buf_sel] = 1'b1;
            mcu_done             = last_block;
            if (last_block && last_mcu) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d = WAIT_BUF;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         buf_sel      <= '0;
         block_idx_q  <= '0;
         mcu_count_q  <= '0;
         frame_mcus_q <= '0;
         armed_q      <= 1'b0;
         component    <= 2'd0;
         dc_reset     <= 1'b0;
      end else begin
         dc_reset <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  frame_mcus_q <= (frame_mcus == '0) ? MCU_WIDTH'(1) : frame_mcus;
                  mcu_count_q  <= '0;
                  block_idx_q  <= '0;
                  buf_sel      <= '0;
                  component    <= 2'd0;
                  armed_q      <= 1'b0;
                  dc_reset     <= 1'b1;
               end
            end
            START: armed_q <= 1'b0;
            RUN: begin
               if (!huff_finished) armed_q <= 1'b1;
            end
            RELEASE: begin
               buf_sel     <= next_sel;
               block_idx_q <= next_block;
               component   <= component_of(next_block);
               if (last_block) mcu_count_q <= mcu_count_q + MCU_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef JPEG_HUFF_SCHED_STALL_COUNT_EN
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         stall_cycles <= '0;
      end else if (state_q == IDLE && frame_start) begin
         stall_cycles <= '0;
      end else if (state_q == WAIT_BUF && stall_cycles != 32'hFFFF_FFFF) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jpeg_huffman_block_scheduler.sv
// Randomized bench for jpeg_huffman_block_scheduler: a block-level event model predicts every output each cycle.
module tb_jpeg_huffman_block_scheduler;

   localparam int NB  = 2;
   localparam int LB  = 4;
   localparam int CB  = 2;
   localparam int BPM = LB + CB;

   logic          clock;
   logic          nreset;
   logic          frame_start;
   logic [15:0]   frame_mcus;
   logic [NB-1:0] buf_full;
   logic [NB-1:0] buf_release;
   logic [0:0]    buf_sel;
   logic          huff_start;
   logic          huff_finished;
   logic [1:0]    component;
   logic          dc_reset;
   logic          mcu_done;
   logic          frame_done;
   logic          busy;
`ifdef JPEG_HUFF_SCHED_STALL_COUNT_EN
   logic [31:0]   stall_cycles;
`endif

   jpeg_huffman_block_scheduler #(
      .NUM_BUFFERS(NB), .LUMA_BLOCKS(LB), .CHROMA_BLOCKS(CB), .MCU_WIDTH(16)
   ) dut (
      .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_mcus(frame_mcus),
      .buf_full(buf_full), .buf_release(buf_release), .buf_sel(buf_sel),
      .huff_start(huff_start), .huff_finished(huff_finished), .component(component),
      .dc_reset(dc_reset), .mcu_done(mcu_done), .frame_done(frame_done), .busy(busy)
`ifdef JPEG_HUFF_SCHED_STALL_COUNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int errors  = 0;

   // Reference model: frame progress in blocks plus the cycles at which each event must appear.
   int          cyc = 0;
   int          blk = 0;
   int          total = 0;
   int          start_at = -1;
   int          release_at = -1;
   int          dc_at = -1;
   int          wait_from = 0;
   int          fin_lo = -1;
   int          fin_hi = -1;
   int          hold1_until = 0;
   int          starts_seen = 0;
   bit          busy_e = 1'b0;
   bit          waiting = 1'b0;
   bit          full_mode = 1'b0;
   bit          stall_mode = 1'b0;
   bit          fs_req = 1'b0;
   logic [15:0] fs_val = '0;
   logic [31:0] stall_e = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [1:0] comp_of(input int b);
      if (b < LB) return 2'd0;
      return (b == LB) ? 2'd1 : 2'd2;
   endfunction

   task automatic reset_model();
      busy_e = 1'b0; waiting = 1'b0; blk = 0; total = 0;
      start_at = -1; release_at = -1; dc_at = -1;
      fin_lo = -1; fin_hi = -1; hold1_until = 0; stall_e = '0;
   endtask

   task automatic step();
      bit          in_wait;
      logic [NB-1:0] rel_e;
      int          h;
      @(negedge clock);
      cyc++;
      rel_e = '0;
      if (cyc == release_at) rel_e[blk % NB] = 1'b1;
      check("busy", busy, busy_e);
      check("huff_start", huff_start, cyc == start_at);
      check("dc_reset", dc_reset, cyc == dc_at);
      check("buf_release", buf_release, rel_e);
      check("mcu_done", mcu_done, (cyc == release_at) && (blk % BPM == BPM - 1));
      check("frame_done", frame_done, (cyc == release_at) && (blk == total - 1));
      check("buf_sel", buf_sel, blk % NB);
      check("component", component, comp_of(blk % BPM));
`ifdef JPEG_HUFF_SCHED_STALL_COUNT_EN
      check("stall_cycles", stall_cycles, stall_e);
`endif
      if (huff_start) starts_seen++;

      // Inputs for this cycle.
      frame_start = fs_req;
      frame_mcus  = fs_val;
      fs_req      = 1'b0;
      buf_full    = full_mode ? NB'($urandom) : '1;
      if (cyc < hold1_until) buf_full[1] = 1'b0;
      if (cyc == start_at) begin
         h          = (blk == 0) ? 3 : $urandom_range(0, 3);
         fin_lo     = cyc + h + 1;
         fin_hi     = fin_lo + $urandom_range(1, 4);
         release_at = fin_hi + 1;
      end
      if (fin_lo >= 0 && cyc >= fin_lo && cyc < fin_hi) huff_finished = 1'b0;
      else if (fin_lo >= 0 && cyc >= fin_hi) huff_finished = 1'b1;

      // Expectations for the next cycle.
      in_wait = waiting && (cyc >= wait_from);
      if (in_wait && buf_full[blk % NB]) begin
         start_at = cyc + 1;
         waiting  = 1'b0;
      end
      if (frame_start && !busy_e) begin
         busy_e    = 1'b1;
         dc_at     = cyc + 1;
         blk       = 0;
         total     = ((frame_mcus == 0) ? 1 : int'(frame_mcus)) * BPM;
         waiting   = 1'b1;
         wait_from = cyc + 1;
         stall_e   = '0;
      end else if (in_wait) begin
         stall_e = stall_e + 1;
      end
      if (cyc == release_at) begin
         if (stall_mode && (blk % NB == 0)) hold1_until = cyc + 21;
         blk++;
         if (blk == total) begin
            busy_e = 1'b0;
         end else begin
            waiting   = 1'b1;
            wait_from = cyc + 1;
         end
      end
   endtask

   task automatic finish_frame();
      int n = 0;
      do begin
         step();
         n++;
      end while (busy_e && n < 4000);
      check("frame_cycle_budget", n < 4000, 1'b1);
      check("huff_start_count", starts_seen, total);
   endtask

   task automatic run_frame(input logic [15:0] mcus);
      fs_req = 1'b1; fs_val = mcus; starts_seen = 0;
      finish_frame();
   endtask

   initial begin
      nreset = 1'b0; frame_start = 1'b0; frame_mcus = '0;
      buf_full = '0; huff_finished = 1'b0;
      repeat (3) step();
      nreset = 1'b1;
      repeat (2) step();

      // Single MCU, buffers always full.
      full_mode = 1'b0;
      run_frame(16'd1);

      // Several MCUs with randomly filling buffers.
      full_mode = 1'b1;
      run_frame(16'd3);

      // Buffer 1 held empty for 20 cycles after each release of buffer 0.
      full_mode = 1'b0; stall_mode = 1'b1;
      run_frame(16'd1);
      stall_mode = 1'b0;

      // Zero MCUs behaves as one.
      run_frame(16'd0);

      // Second frame_start while busy is ignored.
      fs_req = 1'b1; fs_val = 16'd2; starts_seen = 0;
      repeat (15) step();
      fs_req = 1'b1; fs_val = 16'd5;
      finish_frame();

      // Reset during RUN, then restart.
      fs_req = 1'b1; fs_val = 16'd2; starts_seen = 0;
      begin
         int n = 0;
         do begin
            step();
            n++;
         end while (!(start_at >= 0 && cyc == start_at + 2) && n < 500);
      end
      #2 nreset = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_huff_start", huff_start, 1'b0);
      check("rst_buf_release", buf_release, '0);
      check("rst_buf_sel", buf_sel, '0);
      check("rst_component", component, 2'd0);
      check("rst_pulses", {dc_reset, mcu_done, frame_done}, 3'b000);
      reset_model();
      repeat (2) step();
      nreset = 1'b1;
      run_frame(16'd1);

      // Random frames.
      full_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 3)) step();
         run_frame(16'($urandom_range(0, 2)));
      end
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
